gps_sample_buf: RTL and testbench

//   Capture buffer downstream of the GPS top-level 1-bit sample register (I_sign retimed on clk).
//   On a restart command it packs a fixed-length burst of samples MSB-first into WORD_BITS-bit words.
//   It stores them in on-chip RAM, then returns them to the host one word per read strobe on gps_dout.

---
 rtl/gps_sample_buf_if.sv | 13 +
 rtl/gps_sample_buf.sv | 104 ++++++++++
 tb/tb_gps_sample_buf.sv | 119 +++++++++++
 3 files changed

// File: rtl/gps_sample_buf_if.sv
// gps_sample_buf_if: host/capture bundle between the sample source, host reader and the buffer
interface gps_sample_buf_if #(parameter int WORD_BITS = 16);
  logic                 restart;
  logic                 din;
  logic                 rd;
  logic [WORD_BITS-1:0] dout;
  logic                 busy;
  logic                 done;
  logic                 rd_err;
  logic                 rd_wrap;
  modport master (output restart, din, rd, input dout, busy, done, rd_err, rd_wrap);
  modport slave  (input restart, din, rd, output dout, busy, done, rd_err, rd_wrap);
endinterface

// File: rtl/gps_sample_buf.sv
// gps_sample_buf: packs a restart-aligned burst of 1-bit GPS samples into RAM words and replays them to the host
module gps_sample_buf #(
  parameter int WORD_BITS   = 16,
  parameter int DEPTH_WORDS = 1023,
  parameter int AW          = 10
) (
  input logic             clk,
  input logic             rst,
  gps_sample_buf_if.slave bus
);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [BW-1:0] BLAST = BW'(WORD_BITS - 1);
  localparam logic [AW-1:0] ALAST = AW'(DEPTH_WORDS - 1);
  typedef enum logic [1:0] {IDLE, CAPTURE, PRIME, DONE} state_t;
  state_t               state_q, state_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [AW-1:0]        waddr_q, waddr_d, raddr_q, raddr_d, addr;
  logic [WORD_BITS-2:0] shreg_q, shreg_d;
  logic                 err_q, err_d, wrap_q, wrap_d, we, re;
  logic [WORD_BITS-1:0] dout_q;
  logic [WORD_BITS-1:0] mem [DEPTH_WORDS];
  // Single RAM port: the write pointer owns it while capturing, the read pointer otherwise
  assign addr        = (state_q == CAPTURE) ? waddr_q : raddr_q;
  assign bus.dout    = dout_q;
  assign bus.busy    = (state_q == CAPTURE);
  assign bus.done    = (state_q == DONE);
  assign bus.rd_err  = err_q;
  assign bus.rd_wrap = wrap_q;
  // Next-state logic: restart overrides everything, including a simultaneous rd
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    shreg_d  = shreg_q;
    err_d    = err_q;
    wrap_d   = wrap_q;
    we       = 1'b0;
    re       = 1'b0;
    if (bus.restart) begin
      state_d  = CAPTURE;
      bitcnt_d = '0;
      waddr_d  = '0;
      raddr_d  = '0;
      err_d    = 1'b0;
      wrap_d   = 1'b0;
    end else begin
      err_d = err_q | (bus.rd & (state_q != DONE));
      case (state_q)
        CAPTURE: begin
          shreg_d  = {shreg_q[WORD_BITS-3:0], bus.din};
          bitcnt_d = (bitcnt_q == BLAST) ? '0 : bitcnt_q + 1'b1;
          if (bitcnt_q == BLAST) begin
            we      = 1'b1;
            state_d = (waddr_q == ALAST) ? PRIME : CAPTURE;
            waddr_d = (waddr_q == ALAST) ? waddr_q : waddr_q + 1'b1;
          end
        end
        PRIME: begin
          re      = 1'b1;
          raddr_d = '0;
          state_d = DONE;
        end
        DONE: begin
          re = 1'b1;
          if (bus.rd) begin
            raddr_d = (raddr_q == ALAST) ? '0 : raddr_q + 1'b1;
            wrap_d  = wrap_q | (raddr_q == ALAST);
          end
        end
        default: ;
      endcase
    end
  end
  // Control and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      shreg_q  <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      shreg_q  <= shreg_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end
  // Sample RAM write; the completed word is the shift register plus the bit arriving now
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= {shreg_q, bus.din};
  end
  // Registered read: dout follows the read pointer one edge late and holds outside PRIME/DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else if (re) dout_q <= mem[addr];
  end
endmodule

// File: tb/tb_gps_sample_buf.sv
// tb_gps_sample_buf: directed checks of capture timing, readback, wrap, error flags and async reset
module tb_gps_sample_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  gps_sample_buf_if #(.WORD_BITS(16)) bus ();
  gps_sample_buf #(.WORD_BITS(16), .DEPTH_WORDS(4), .AW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic capture(input logic [63:0] pat, input int rd_at, input logic rd_same);
    bus.restart = 1'b1;
    bus.rd = rd_same;
    tick();
    bus.restart = 1'b0;
    bus.rd = 1'b0;
    chk(16'(bus.busy), 16'd1, "busy_after_restart");
    chk(16'(bus.done), 16'd0, "done_after_restart");
    chk(16'(bus.rd_err), 16'd0, "rd_err_cleared");
    chk(16'(bus.rd_wrap), 16'd0, "rd_wrap_cleared");
    for (int i = 0; i < 64; i++) begin
      bus.din = pat[63-i];
      bus.rd = (i == rd_at);
      tick();
      if (i == 62) chk(16'(bus.busy), 16'd1, "busy_edge63");
    end
    bus.rd = 1'b0;
    chk(16'(bus.busy), 16'd0, "busy_edge64");
    chk(16'(bus.done), 16'd0, "done_edge64");
    tick();
    chk(16'(bus.done), 16'd1, "done_edge65");
    chk(bus.dout, pat[63:48], "dout_word0");
  endtask
  task automatic read_word(input logic [15:0] exp, input string tag);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    tick();
    chk(bus.dout, exp, tag);
  endtask
  initial begin
    bus.restart = 1'b0;
    bus.din = 1'b0;
    bus.rd = 1'b0;
    tick();
    tick();
    chk(bus.dout, 16'h0, "reset_dout");
    chk(16'({bus.busy, bus.done, bus.rd_err, bus.rd_wrap}), 16'h0, "reset_flags");
    rst = 1'b0;
    tick();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    chk(16'(bus.rd_err), 16'd1, "rd_in_idle_err");
    chk(bus.dout, 16'h0, "rd_in_idle_dout");
    capture({16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001}, -1, 1'b0);
    chk(16'(bus.rd_err), 16'd0, "t2_rd_err");
    read_word(16'h1234, "t2_word1");
    read_word(16'hFFFF, "t2_word2");
    read_word(16'h0001, "t2_word3");
    chk(16'(bus.rd_wrap), 16'd0, "t2_no_wrap");
    read_word(16'hA5C3, "t3_wrap_word0");
    chk(16'(bus.rd_wrap), 16'd1, "t3_rd_wrap");
    chk(16'(bus.rd_err), 16'd0, "t3_rd_err");
    capture({16'hA5C3, 16'h1234, 16'hFFFF, 16'h0001}, 9, 1'b0);
    chk(16'(bus.rd_err), 16'd1, "t4_rd_err");
    read_word(16'h1234, "t4_word1");
    read_word(16'hFFFF, "t4_word2");
    read_word(16'h0001, "t4_word3");
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk(bus.dout, 16'h0001, "t5_dout_holds");
    for (int i = 0; i < 29; i++) begin
      bus.din = i[0] ^ i[2];
      tick();
    end
    capture({16'hDEAD, 16'hBEEF, 16'h0F0F, 16'h8000}, -1, 1'b0);
    read_word(16'hBEEF, "t5_word1");
    read_word(16'h0F0F, "t5_word2");
    read_word(16'h8000, "t5_word3");
    read_word(16'hDEAD, "t5_wrap_word0");
    read_word(16'hBEEF, "t6_pre_word1");
    capture({16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}, -1, 1'b1);
    chk(16'(bus.rd_err), 16'd0, "t6_rd_err");
    read_word(16'h4567, "t6_word1");
    read_word(16'h89AB, "t6_word2");
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.din = 1'b1;
      bus.rd = (i == 3);
      tick();
    end
    bus.rd = 1'b0;
    chk(16'(bus.rd_err), 16'd1, "t1_err_before_rst");
    #1 rst = 1'b1;
    #1;
    chk(bus.dout, 16'h0, "t1_async_dout");
    chk(16'({bus.busy, bus.done, bus.rd_err, bus.rd_wrap}), 16'h0, "t1_async_flags");
    tick();
    rst = 1'b0;
    tick();
    chk(16'({bus.busy, bus.done}), 16'h0, "t1_idle_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
